// File: rtl/dla_pkg.sv
// Shared types for the DLA controller front end: fetch FSM states, the unpacked
// layer descriptor, and the helpers that decode and validate a raw descriptor.
package dla_pkg;

  localparam int         DESC_WORDS = 8;
  localparam int         WORD_IDX_W = $clog2(DESC_WORDS);
  localparam logic [3:0] LT_MAX     = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_R,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DONE
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] quant_scale;
    logic [15:0] flags;
    logic [31:0] base_ofmap;
    logic [31:0] base_bias;
    logic [31:0] base_weight;
    logic [31:0] base_ifmap;
    logic [15:0] out_K;
    logic [15:0] in_D;
    logic [15:0] in_C;
    logic [15:0] in_R;
    logic [3:0]  pad_R;
    logic [3:0]  pad_L;
    logic [3:0]  pad_B;
    logic [3:0]  pad_T;
    logic [3:0]  stride;
    logic [3:0]  layer_type;
    logic [7:0]  layer_id;
  } layer_desc_t;

  typedef logic [DESC_WORDS-1:0][31:0] desc_words_t;

  function automatic layer_desc_t desc_unpack(input desc_words_t w);
    layer_desc_t d;
    d.layer_id    = w[0][7:0];
    d.layer_type  = w[0][11:8];
    d.stride      = w[0][15:12];
    d.pad_T       = w[0][19:16];
    d.pad_B       = w[0][23:20];
    d.pad_L       = w[0][27:24];
    d.pad_R       = w[0][31:28];
    d.in_R        = w[1][15:0];
    d.in_C        = w[1][31:16];
    d.in_D        = w[2][15:0];
    d.out_K       = w[2][31:16];
    d.base_ifmap  = w[3];
    d.base_weight = w[4];
    d.base_bias   = w[5];
    d.base_ofmap  = w[6];
    d.flags       = w[7][15:0];
    d.quant_scale = w[7][31:16];
    return d;
  endfunction

  // Only layer types 0..LT_MAX exist and the datapath supports stride 1 or 2.
  function automatic logic desc_is_bad(input layer_desc_t d);
    return (d.layer_type > LT_MAX) || !((d.stride == 4'd1) || (d.stride == 4'd2));
  endfunction

endpackage

// File: rtl/layer_desc_fetcher.sv
// Sequences a whole network: fetches each layer's descriptor one word at a time,
// validates it, hands the unpacked fields to the decoder and waits for the layer.
module layer_desc_fetcher
  import dla_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LAYER_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] desc_base_i,
  input  logic [LAYER_W-1:0] num_layers_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  input  logic              layer_done_i,
  output logic              uLD_en_o,
  output logic [7:0]        layer_id_o,
  output logic [3:0]        layer_type_o,
  output logic [3:0]        stride_o,
  output logic [3:0]        pad_T_o,
  output logic [3:0]        pad_B_o,
  output logic [3:0]        pad_L_o,
  output logic [3:0]        pad_R_o,
  output logic [15:0]       in_R_o,
  output logic [15:0]       in_C_o,
  output logic [15:0]       in_D_o,
  output logic [15:0]       out_K_o,
  output logic [31:0]       base_ifmap_o,
  output logic [31:0]       base_weight_o,
  output logic [31:0]       base_bias_o,
  output logic [31:0]       base_ofmap_o,
  output logic [15:0]       flags_o,
  output logic [15:0]       quant_scale_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  fetch_state_e          state_q, state_d;
  logic [WORD_IDX_W-1:0] word_idx_q, word_idx_d;
  logic [LAYER_W-1:0]    layer_idx_q, layer_idx_d;
  logic [LAYER_W-1:0]    num_layers_q, num_layers_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic                  err_q, err_d;
  layer_desc_t           fields_q, fields_d;
  desc_words_t           words_q;
  layer_desc_t           fetched;
  logic                  load_word, mem_req, uld_en, done;
  logic                  last_layer;
  logic [ADDR_W-1:0]     req_addr;

  assign fetched    = desc_unpack(words_q);
  assign last_layer = (layer_idx_q + LAYER_W'(1)) == num_layers_q;
  // Byte address; wraps silently at 2^ADDR_W.
  assign req_addr   = base_q
                    + ADDR_W'(layer_idx_q) * ADDR_W'(DESC_WORDS * 4)
                    + ADDR_W'(word_idx_q) * ADDR_W'(4);

  // NOTE: every always_comb output is defaulted before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    word_idx_d   = word_idx_q;
    layer_idx_d  = layer_idx_q;
    num_layers_d = num_layers_q;
    base_d       = base_q;
    err_d        = err_q;
    fields_d     = fields_q;
    load_word    = 1'b0;
    mem_req      = 1'b0;
    uld_en       = 1'b0;
    done         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d       = desc_base_i;
          num_layers_d = num_layers_i;
          word_idx_d   = '0;
          layer_idx_d  = '0;
          err_d        = 1'b0;
          state_d      = (num_layers_i == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt_i) state_d = ST_WAIT_R;
      end
      ST_WAIT_R: begin
        if (mem_rvalid_i) begin
          load_word = 1'b1;
          if (word_idx_q == WORD_IDX_W'(DESC_WORDS - 1)) begin
            state_d = ST_CHECK;
          end else begin
            word_idx_d = word_idx_q + WORD_IDX_W'(1);
            state_d    = ST_REQ;
          end
        end
      end
      ST_CHECK: begin
        if (desc_is_bad(fetched)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          fields_d = fetched;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        uld_en  = 1'b1;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (layer_done_i) begin
          if (last_layer) begin
            state_d = ST_DONE;
          end else begin
            layer_idx_d = layer_idx_q + LAYER_W'(1);
            word_idx_d  = '0;
            state_d     = ST_REQ;
          end
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides whatever the state decided this cycle; err_o survives it.
    if (abort_i && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      err_d     = err_q;
      fields_d  = fields_q;
      load_word = 1'b0;
      mem_req   = 1'b0;
      uld_en    = 1'b0;
      done      = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      word_idx_q   <= '0;
      layer_idx_q  <= '0;
      num_layers_q <= '0;
      base_q       <= '0;
      err_q        <= 1'b0;
      fields_q     <= '0;
    end else begin
      state_q      <= state_d;
      word_idx_q   <= word_idx_d;
      layer_idx_q  <= layer_idx_d;
      num_layers_q <= num_layers_d;
      base_q       <= base_d;
      err_q        <= err_d;
      fields_q     <= fields_d;
    end
  end

  // NOTE: the word buffer has no reset; every word is rewritten before CHECK ever reads it.
  always_ff @(posedge clk) begin
    if (load_word) words_q[word_idx_q] <= mem_rdata_i;
  end

  assign mem_req_o     = mem_req;
  assign mem_addr_o    = mem_req ? req_addr : '0;
  assign uLD_en_o      = uld_en;
  assign done_o        = done;
  assign busy_o        = (state_q != ST_IDLE);
  assign err_o         = err_q;
  assign layer_id_o    = fields_q.layer_id;
  assign layer_type_o  = fields_q.layer_type;
  assign stride_o      = fields_q.stride;
  assign pad_T_o       = fields_q.pad_T;
  assign pad_B_o       = fields_q.pad_B;
  assign pad_L_o       = fields_q.pad_L;
  assign pad_R_o       = fields_q.pad_R;
  assign in_R_o        = fields_q.in_R;
  assign in_C_o        = fields_q.in_C;
  assign in_D_o        = fields_q.in_D;
  assign out_K_o       = fields_q.out_K;
  assign base_ifmap_o  = fields_q.base_ifmap;
  assign base_weight_o = fields_q.base_weight;
  assign base_bias_o   = fields_q.base_bias;
  assign base_ofmap_o  = fields_q.base_ofmap;
  assign flags_o       = fields_q.flags;
  assign quant_scale_o = fields_q.quant_scale;

endmodule

// File: tb/tb_layer_desc_fetcher.sv
// Scoreboard bench for layer_desc_fetcher: a memory responder, a tile-scheduler
// stand-in and output monitors check against hand-computed descriptors.
module tb_layer_desc_fetcher;
  import dla_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0, abort_i = 1'b0;
  logic [31:0] desc_base_i = '0;
  logic [7:0]  num_layers_i = '0;
  logic        mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_addr_o, mem_rdata_i = '0;
  logic        layer_done_i = 1'b0;
  logic        uLD_en_o, busy_o, done_o, err_o;
  logic [7:0]  layer_id_o;
  logic [3:0]  layer_type_o, stride_o, pad_T_o, pad_B_o, pad_L_o, pad_R_o;
  logic [15:0] in_R_o, in_C_o, in_D_o, out_K_o, flags_o, quant_scale_o;
  logic [31:0] base_ifmap_o, base_weight_o, base_bias_o, base_ofmap_o;

  int total = 0, bad = 0, cyc = 0, t_start = 0;
  logic stall_en = 1'b0, abort_next = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_addr_q [$];
  typedef struct { layer_desc_t d; int lat; } uld_exp_t;
  typedef struct { logic err; int max_lat; } done_exp_t;
  uld_exp_t  exp_uld_q [$];
  done_exp_t exp_done_q [$];
  layer_desc_t exp_l0, exp_l1, exp_l2, act_desc;

  layer_desc_fetcher #(.ADDR_W(32), .LAYER_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .desc_base_i(desc_base_i), .num_layers_i(num_layers_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .layer_done_i(layer_done_i),
    .uLD_en_o(uLD_en_o), .layer_id_o(layer_id_o), .layer_type_o(layer_type_o),
    .stride_o(stride_o), .pad_T_o(pad_T_o), .pad_B_o(pad_B_o), .pad_L_o(pad_L_o),
    .pad_R_o(pad_R_o), .in_R_o(in_R_o), .in_C_o(in_C_o), .in_D_o(in_D_o),
    .out_K_o(out_K_o), .base_ifmap_o(base_ifmap_o), .base_weight_o(base_weight_o),
    .base_bias_o(base_bias_o), .base_ofmap_o(base_ofmap_o), .flags_o(flags_o),
    .quant_scale_o(quant_scale_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic layer_desc_t mk_desc(
      input logic [7:0] id, input logic [3:0] typ, st, pt, pb, pl, pr,
      input logic [15:0] ir, ic, idd, ok, input logic [31:0] bi, bw, bb, bo,
      input logic [15:0] fl, qs);
    layer_desc_t d;
    d.layer_id = id;  d.layer_type = typ; d.stride = st;
    d.pad_T = pt; d.pad_B = pb; d.pad_L = pl; d.pad_R = pr;
    d.in_R = ir; d.in_C = ic; d.in_D = idd; d.out_K = ok;
    d.base_ifmap = bi; d.base_weight = bw; d.base_bias = bb; d.base_ofmap = bo;
    d.flags = fl; d.quant_scale = qs;
    return d;
  endfunction

  always_comb act_desc = mk_desc(layer_id_o, layer_type_o, stride_o, pad_T_o, pad_B_o,
                                 pad_L_o, pad_R_o, in_R_o, in_C_o, in_D_o, out_K_o,
                                 base_ifmap_o, base_weight_o, base_bias_o, base_ofmap_o,
                                 flags_o, quant_scale_o);

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] val);
    total++;
    bad++;
    $display("FAIL %s @cyc %0d: unexpected event, value %0h", name, cyc, val);
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  // Memory slave: grant after an optional stall, data after another.
  initial begin : responder
    logic [31:0] a;
    int dly;
    forever begin
      @(negedge clk);
      mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; abort_i = 1'b0;
      if (mem_req_o) begin
        if (stall_en) begin
          dly = $urandom_range(0, 7);
          repeat (dly) @(negedge clk);
        end
        a = mem_addr_o;
        if (exp_addr_q.size() == 0) flag_fail("req_unexpected", a);
        else check("req_addr", a, exp_addr_q.pop_front());
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        dly = stall_en ? $urandom_range(0, 7) : 0;
        if (abort_next) begin
          abort_i = 1'b1; abort_next = 1'b0; dly = 1;
        end
        repeat (dly) begin
          @(negedge clk);
          abort_i = 1'b0;
        end
        check("req_low_while_read", mem_req_o, 1'b0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd(a);
      end
    end
  end

  initial begin : tile_sched
    forever begin
      @(negedge clk);
      if (uLD_en_o) begin
        repeat (5) @(negedge clk);
        layer_done_i = 1'b1;
        @(negedge clk);
        layer_done_i = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : uld_monitor
    uld_exp_t e;
    if (uLD_en_o) begin
      if (exp_uld_q.size() == 0) flag_fail("uld_unexpected", {24'h0, layer_id_o});
      else begin
        e = exp_uld_q.pop_front();
        check("uld_fields", act_desc, e.d);
        if (e.lat >= 0) check("uld_latency", 32'(cyc - t_start), 32'(e.lat));
      end
    end
  end

  always @(negedge clk) begin : done_monitor
    done_exp_t e;
    if (done_o) begin
      if (exp_done_q.size() == 0) flag_fail("done_unexpected", 32'(cyc));
      else begin
        e = exp_done_q.pop_front();
        check("done_err", err_o, e.err);
        if (e.max_lat > 0) check("done_latency_ok", (cyc - t_start) <= e.max_lat, 1'b1);
      end
    end
  end

  task automatic push_layer(input logic [31:0] base, input int layer, input layer_desc_t d, input int lat);
    uld_exp_t e;
    for (int w = 0; w < DESC_WORDS; w++) exp_addr_q.push_back(base + 32'(layer * 32) + 32'(w * 4));
    e.d = d; e.lat = lat;
    exp_uld_q.push_back(e);
  endtask

  task automatic expect_done(input logic err, input int max_lat);
    done_exp_t e;
    e.err = err; e.max_lat = max_lat;
    exp_done_q.push_back(e);
  endtask

  task automatic start_run(input logic [31:0] base, input logic [7:0] n);
    @(negedge clk);
    desc_base_i = base; num_layers_i = n; start_i = 1'b1; t_start = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((exp_done_q.size() != 0 || busy_o) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_no_timeout"}, n < 3000, 1'b1);
    check({name, "_addrs_drained"}, 32'(exp_addr_q.size()), 32'd0);
    check({name, "_ulds_drained"}, 32'(exp_uld_q.size()), 32'd0);
  endtask

  initial begin : main
    logic [31:0] tbl [24] = '{
      32'h4321_1105, 32'h0020_0040, 32'h0080_0010, 32'hA000_0000,
      32'hA100_0000, 32'hA200_0000, 32'hA300_0000, 32'h3C00_00F1,
      32'h0000_2306, 32'h0010_0011, 32'h0100_0003, 32'hB000_0000,
      32'hB100_0000, 32'hB200_0000, 32'hB300_0000, 32'h1234_5678,
      32'h1111_1007, 32'h0007_0009, 32'h0040_0020, 32'hC000_0000,
      32'hC100_0000, 32'hC200_0000, 32'hC300_0000, 32'h0001_0002};
    for (int i = 0; i < 24; i++) mem[32'h1000 + 32'(4 * i)] = tbl[i];
    mem[32'h2000] = 32'h0000_1509;

    exp_l0 = mk_desc(8'h05, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 16'h0040, 16'h0020, 16'h0010,
                     16'h0080, 32'hA000_0000, 32'hA100_0000, 32'hA200_0000, 32'hA300_0000,
                     16'h00F1, 16'h3C00);
    exp_l1 = mk_desc(8'h06, 4'd3, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 16'h0011, 16'h0010, 16'h0003,
                     16'h0100, 32'hB000_0000, 32'hB100_0000, 32'hB200_0000, 32'hB300_0000,
                     16'h5678, 16'h1234);
    exp_l2 = mk_desc(8'h07, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 16'h0009, 16'h0007, 16'h0020,
                     16'h0040, 32'hC000_0000, 32'hC100_0000, 32'hC200_0000, 32'hC300_0000,
                     16'h0002, 16'h0001);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_uld", uLD_en_o, 1'b0);
    check("rst_req", mem_req_o, 1'b0);
    check("rst_addr", mem_addr_o, 32'h0);
    check("rst_err", err_o, 1'b0);
    check("rst_fields", act_desc, '0);

    // Single layer, no stalls: 18-cycle start to uLD_en_o.
    push_layer(32'h1000, 0, exp_l0, 18);
    expect_done(1'b0, 0);
    start_run(32'h1000, 8'd1);
    wait_quiet("one_layer");

    // Three layers back to back.
    push_layer(32'h1000, 0, exp_l0, -1);
    push_layer(32'h1000, 1, exp_l1, -1);
    push_layer(32'h1000, 2, exp_l2, -1);
    expect_done(1'b0, 0);
    start_run(32'h1000, 8'd3);
    wait_quiet("three_layers");

    // Same network with random grant/data stalls.
    stall_en = 1'b1;
    push_layer(32'h1000, 0, exp_l0, -1);
    push_layer(32'h1000, 1, exp_l1, -1);
    push_layer(32'h1000, 2, exp_l2, -1);
    expect_done(1'b0, 0);
    start_run(32'h1000, 8'd3);
    wait_quiet("stalled");
    stall_en = 1'b0;

    // Bad layer type: error, no issue, fields hold the last issued layer.
    for (int w = 0; w < DESC_WORDS; w++) exp_addr_q.push_back(32'h2000 + 32'(w * 4));
    expect_done(1'b1, 0);
    start_run(32'h2000, 8'd2);
    wait_quiet("bad_type");
    check("err_sticky", err_o, 1'b1);
    check("fields_held", act_desc, exp_l2);

    // A new start clears the error.
    push_layer(32'h1000, 0, exp_l0, -1);
    expect_done(1'b0, 0);
    start_run(32'h1000, 8'd1);
    check("err_cleared", err_o, 1'b0);
    wait_quiet("after_err");

    // Abort while waiting for word 0; late data is dropped, restart begins at word 0.
    abort_next = 1'b1;
    exp_addr_q.push_back(32'h1000);
    start_run(32'h1000, 8'd1);
    wait_quiet("abort");
    check("abort_busy", busy_o, 1'b0);
    push_layer(32'h1000, 0, exp_l0, 18);
    expect_done(1'b0, 0);
    start_run(32'h1000, 8'd1);
    wait_quiet("restart");

    // Zero layers: quick done, no memory traffic.
    expect_done(1'b0, 2);
    start_run(32'h1000, 8'd0);
    wait_quiet("zero_layers");

    // start_i while busy is ignored.
    push_layer(32'h1000, 0, exp_l0, -1);
    expect_done(1'b0, 0);
    start_run(32'h1000, 8'd1);
    repeat (3) @(negedge clk);
    desc_base_i = 32'h2000; num_layers_i = 8'd5; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_quiet("start_busy");

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
